relogio_ajustavel: RTL
======================

// Module: relogio_ajustavel
// PURPOSE
//  Parametrised HH:MM:SS clock core. Successor to the fixed 24 h clock top.
//  Adds a generic clock-rate prescaler, 12 h or 24 h display mode, and button-driven time setting.
//  The field being set blinks. Drives six 7-segment digits plus a PM indicator.
// PARAMETERS
//  CLK_FREQ_HZ     50_000_000  main_clock frequency; prescaler period; must be >=4 and divisible by 4
//  MODE_24H        1           1: hours shown 00..23; 0: hours shown 12,01..11 with pm flag
//  SEG_ACTIVE_LOW  1           1: segment on = 0 (DE-board style); 0: segment on = 1
// PORTS
//  main_clock  in   1  single clock domain
//  main_reset  in   1  synchronous, active-high; priority over every other input
//  btn_mode    in   1  level, already debounced and synchronised; rising edge cycles mode
//  btn_inc     in   1  level, already debounced and synchronised; rising edge increments selected field
//  s_lsd/s_msd in/out: out 7 each; seconds digits, seg[6:0]=gfedcba
//  m_lsd/m_msd out  7 each; minutes digits
//  h_lsd/h_msd out  7 each; hours digits (12 h converted when MODE_24H=0)
//  pm          out  1  1 when internal hour >=12 and MODE_24H=0; constant 0 when MODE_24H=1
//  tick_1hz    out  1  one-cycle pulse on prescaler wrap, RUN state only
//  set_state   out  2  00 RUN, 01 SET_H, 10 SET_M
// BEHAVIOUR
//  Reset (registered on the main_clock edge with main_reset=1):
//   - time 00:00:00, state RUN, prescaler 0, blink phase visible
//   - button edge registers 0, tick_1hz 0
//   - displays 00:00:00 (12 h mode: 12:00:00), pm 0
//  Prescaler:
//   - counts 0..CLK_FREQ_HZ-1 in RUN only; held at 0 in SET_H/SET_M
//   - tick_1hz=1 combinationally when count==CLK_FREQ_HZ-1 and state==RUN
//  Time registers (BCD: s_lsd 0-9, s_msd 0-5, m_lsd 0-9, m_msd 0-5, hours binary 0..23 internal):
//   - update on the edge where tick_1hz=1, so digit outputs change one cycle after the tick pulse
//   - carry chain: sec 59->00 incs min; min 59->00 incs hour; hour 23->00; all in that one edge
//  Buttons:
//   - edge = btn & ~btn_q, where btn_q is the previous-cycle sample
//   - a held button produces exactly one edge
//  FSM (advances on btn_mode edge): RUN->SET_H->SET_M->RUN
//   - SET_H: inc edge adds 1 to hour, 23->00, no other field touched
//   - SET_M: inc edge adds 1 to minute, 59->00, no carry into hours
//   - leaving SET_M: seconds cleared to 00 and prescaler cleared on that same edge
//  Simultaneous events:
//   - mode and inc edges in the same cycle: mode wins, inc discarded
//   - tick and mode edge in the same RUN cycle: tick applied, state still advances
//  Blink:
//   - separate counter, half-period CLK_FREQ_HZ/4 cycles (2 Hz); runs only in SET states
//   - counter reset to 0 and phase set visible on entry to any SET state
//   - in blank phase, both digits of the selected field output all segments off
//     (7'h7F if SEG_ACTIVE_LOW, else 7'h00); other fields always shown
//  12 h conversion (MODE_24H=0):
//   - displayed hour = (h%12==0) ? 12 : h%12
//   - pm = (h>=12)
//  Encoding: 0-9 standard gfedcba; active-low 0 = 7'b1000000, 1 = 7'b1111001
//  All outputs except tick_1hz are decoded from registers; no output depends on btn inputs combinationally
// TESTING (CLK_FREQ_HZ=8 unless stated)
//  1 Reset, run 8 cycles -> all digits 7'b1000000; tick_1hz high at cycle 7; s_lsd shows 1 at cycle 8.
//  2 Set 23:59 via SET_H/SET_M, exit, 59 ticks, 1 more tick -> 00:00:00 in one update, no intermediate value.
//  3 MODE_24H=0: 11:59:59+tick -> 12:00:00 pm 0->1; 23:59:59+tick -> 12:00:00 pm 1->0.
//  4 SET_H at hour 22, three inc pulses -> 23, 00, 01; minutes unchanged; tick_1hz stays 0; blink toggles every 2 cycles.
//  5 btn_inc held 20 cycles -> one increment; mode+inc same cycle -> state advances, field unchanged.
//  6 main_reset asserted in SET_M with 13:27 set -> next cycle RUN, 00:00:00, set_state 00, prescaler 0.

Source files
------------

// File: rtl/relogio_ajustavel.sv
// ----------------------------------------------------------------------------
// relogio_ajustavel
// HH:MM:SS clock core with a generic prescaler, 12 h / 24 h display mode and
// button-driven time setting. The field being set blinks at 2 Hz.
//
// Ports
//   main_clock  in   clock, single domain
//   main_reset  in   synchronous active-high reset, overrides everything
//   btn_mode    in   debounced level; rising edge steps RUN->SET_H->SET_M->RUN
//   btn_inc     in   debounced level; rising edge increments the selected field
//   s_lsd/s_msd out  seconds digits, seg[6:0] = gfedcba
//   m_lsd/m_msd out  minutes digits
//   h_lsd/h_msd out  hours digits (12 h converted when MODE_24H = 0)
//   pm          out  internal hour >= 12 in 12 h mode, else 0
//   tick_1hz    out  one-cycle pulse on prescaler wrap, RUN only
//   set_state   out  00 RUN, 01 SET_H, 10 SET_M
// ----------------------------------------------------------------------------
module relogio_ajustavel #(
    parameter int CLK_FREQ_HZ    = 50_000_000,
    parameter int MODE_24H       = 1,
    parameter int SEG_ACTIVE_LOW = 1
) (
    input  logic       main_clock,
    input  logic       main_reset,
    input  logic       btn_mode,
    input  logic       btn_inc,
    output logic [6:0] s_lsd,
    output logic [6:0] s_msd,
    output logic [6:0] m_lsd,
    output logic [6:0] m_msd,
    output logic [6:0] h_lsd,
    output logic [6:0] h_msd,
    output logic       pm,
    output logic       tick_1hz,
    output logic [1:0] set_state
);

    localparam logic [1:0] ST_RUN   = 2'b00;
    localparam logic [1:0] ST_SET_H = 2'b01;
    localparam logic [1:0] ST_SET_M = 2'b10;

    localparam int PW         = $clog2(CLK_FREQ_HZ);
    localparam int BLINK_HALF = CLK_FREQ_HZ / 4;
    localparam int BW         = $clog2(BLINK_HALF + 1);
    localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_FREQ_HZ - 1);
    localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_HALF - 1);

    logic [1:0]    state_reg, state_next;
    logic [PW-1:0] presc_reg, presc_next;
    logic [BW-1:0] blink_cnt_reg, blink_cnt_next;
    logic          blink_vis_reg, blink_vis_next;
    logic [3:0]    sec_l_reg, sec_l_next, sec_m_reg, sec_m_next;
    logic [3:0]    min_l_reg, min_l_next, min_m_reg, min_m_next;
    logic [4:0]    hour_reg, hour_next;
    logic          mode_q_reg, inc_q_reg;

    logic mode_edge, inc_edge;
    logic sec_wrap, min_wrap, min_inc, hour_inc;

    // A mode edge swallows a coincident inc edge.
    assign mode_edge = btn_mode & ~mode_q_reg;
    assign inc_edge  = btn_inc & ~inc_q_reg & ~mode_edge;

    assign tick_1hz  = (state_reg == ST_RUN) && (presc_reg == PRESC_MAX);
    assign set_state = state_reg;

    always_comb begin
        state_next = state_reg;
        if (mode_edge) begin
            case (state_reg)
                ST_RUN:   state_next = ST_SET_H;
                ST_SET_H: state_next = ST_SET_M;
                default:  state_next = ST_RUN;
            endcase
        end
    end

    // Prescaler only runs while staying in RUN; any SET state holds it at 0,
    // which also gives the clear on leaving SET_M.
    always_comb begin
        presc_next = '0;
        if (state_reg == ST_RUN && state_next == ST_RUN && !tick_1hz)
            presc_next = presc_reg + 1'b1;
    end

    // Time update: tick carry chain plus the setting increments. Tick and the
    // SET increments are mutually exclusive because ticks only occur in RUN.
    assign sec_wrap = tick_1hz && sec_l_reg == 4'd9 && sec_m_reg == 4'd5;
    assign min_wrap = sec_wrap && min_l_reg == 4'd9 && min_m_reg == 4'd5;
    assign min_inc  = sec_wrap || (state_reg == ST_SET_M && inc_edge);
    assign hour_inc = min_wrap || (state_reg == ST_SET_H && inc_edge);

    always_comb begin
        sec_l_next = sec_l_reg;
        sec_m_next = sec_m_reg;
        min_l_next = min_l_reg;
        min_m_next = min_m_reg;
        hour_next  = hour_reg;
        if (tick_1hz) begin
            sec_l_next = (sec_l_reg == 4'd9) ? 4'd0 : sec_l_reg + 4'd1;
            if (sec_l_reg == 4'd9)
                sec_m_next = (sec_m_reg == 4'd5) ? 4'd0 : sec_m_reg + 4'd1;
        end
        if (state_reg == ST_SET_M && mode_edge) begin
            sec_l_next = 4'd0;
            sec_m_next = 4'd0;
        end
        if (min_inc) begin
            min_l_next = (min_l_reg == 4'd9) ? 4'd0 : min_l_reg + 4'd1;
            if (min_l_reg == 4'd9)
                min_m_next = (min_m_reg == 4'd5) ? 4'd0 : min_m_reg + 4'd1;
        end
        if (hour_inc)
            hour_next = (hour_reg == 5'd23) ? 5'd0 : hour_reg + 5'd1;
    end

    // Blink restarts visible on every entry into a SET state and idles in RUN.
    always_comb begin
        blink_cnt_next = '0;
        blink_vis_next = 1'b1;
        if (state_next != ST_RUN && !mode_edge) begin
            if (blink_cnt_reg == BLINK_MAX) begin
                blink_vis_next = ~blink_vis_reg;
            end else begin
                blink_cnt_next = blink_cnt_reg + 1'b1;
                blink_vis_next = blink_vis_reg;
            end
        end
    end

    always_ff @(posedge main_clock) begin
        if (main_reset) begin
            state_reg     <= ST_RUN;
            presc_reg     <= '0;
            blink_cnt_reg <= '0;
            blink_vis_reg <= 1'b1;
            sec_l_reg     <= 4'd0;
            sec_m_reg     <= 4'd0;
            min_l_reg     <= 4'd0;
            min_m_reg     <= 4'd0;
            hour_reg      <= 5'd0;
            mode_q_reg    <= 1'b0;
            inc_q_reg     <= 1'b0;
        end else begin
            state_reg     <= state_next;
            presc_reg     <= presc_next;
            blink_cnt_reg <= blink_cnt_next;
            blink_vis_reg <= blink_vis_next;
            sec_l_reg     <= sec_l_next;
            sec_m_reg     <= sec_m_next;
            min_l_reg     <= min_l_next;
            min_m_reg     <= min_m_next;
            hour_reg      <= hour_next;
            mode_q_reg    <= btn_mode;
            inc_q_reg     <= btn_inc;
        end
    end

    // Display hour conversion and split into two decimal digits.
    logic [4:0] hour_12, hour_disp;
    logic [3:0] hour_tens, hour_ones;

    always_comb begin
        hour_12   = (hour_reg >= 5'd12) ? hour_reg - 5'd12 : hour_reg;
        hour_disp = (MODE_24H != 0) ? hour_reg : ((hour_12 == 5'd0) ? 5'd12 : hour_12);
        hour_tens = 4'd0;
        hour_ones = hour_disp[3:0];
        if (hour_disp >= 5'd20) begin
            hour_tens = 4'd2;
            hour_ones = 4'(hour_disp - 5'd20);
        end else if (hour_disp >= 5'd10) begin
            hour_tens = 4'd1;
            hour_ones = 4'(hour_disp - 5'd10);
        end
    end

    assign pm = (MODE_24H == 0) && (hour_reg >= 5'd12);

    function automatic logic [6:0] seg_on(input logic [3:0] d);
        case (d)
            4'd0:    seg_on = 7'h3F;
            4'd1:    seg_on = 7'h06;
            4'd2:    seg_on = 7'h5B;
            4'd3:    seg_on = 7'h4F;
            4'd4:    seg_on = 7'h66;
            4'd5:    seg_on = 7'h6D;
            4'd6:    seg_on = 7'h7D;
            4'd7:    seg_on = 7'h07;
            4'd8:    seg_on = 7'h7F;
            4'd9:    seg_on = 7'h6F;
            default: seg_on = 7'h00;
        endcase
    endfunction

    // Digit index: 0 s_lsd, 1 s_msd, 2 m_lsd, 3 m_msd, 4 h_lsd, 5 h_msd.
    logic [3:0] digit [6];
    logic       blank [6];
    logic [6:0] seg   [6];
    logic       blank_h, blank_m;

    assign blank_h = (state_reg == ST_SET_H) && !blink_vis_reg;
    assign blank_m = (state_reg == ST_SET_M) && !blink_vis_reg;

    assign digit[0] = sec_l_reg;
    assign digit[1] = sec_m_reg;
    assign digit[2] = min_l_reg;
    assign digit[3] = min_m_reg;
    assign digit[4] = hour_ones;
    assign digit[5] = hour_tens;
    assign blank[0] = 1'b0;
    assign blank[1] = 1'b0;
    assign blank[2] = blank_m;
    assign blank[3] = blank_m;
    assign blank[4] = blank_h;
    assign blank[5] = blank_h;

    generate
        for (genvar gi = 0; gi < 6; gi++) begin : g_seg
            logic [6:0] raw;
            assign raw     = blank[gi] ? 7'h00 : seg_on(digit[gi]);
            assign seg[gi] = (SEG_ACTIVE_LOW != 0) ? ~raw : raw;
        end
    endgenerate

    assign s_lsd = seg[0];
    assign s_msd = seg[1];
    assign m_lsd = seg[2];
    assign m_msd = seg[3];
    assign h_lsd = seg[4];
    assign h_msd = seg[5];

endmodule
